// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types and decode helpers for the SDRAM command sequencer
package sdram_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_HW  = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_LAT_WAIT,
    ST_XFER,
    ST_RECOVER
  } state_e;

  function automatic logic [3:0] len_beats(input logic [1:0] len);
    return 4'd1 << len;
  endfunction

  function automatic logic [7:0] col_inc(input logic [1:0] size);
    case (size)
      SZ_HW:   return 8'd2;
      SZ_W:    return 8'd4;
      default: return 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// rtl/sdram_wr_fifo.sv - write-data FIFO; an empty FIFO passes a same-cycle push straight to the head
module sdram_wr_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  // Push and pop together while empty leaves both pointers aligned: a pure bypass.
  assign pop_data = empty ? push_data : mem[rptr];
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// rtl/sdram_cmd_sequencer.sv - expands one burst request into the SDRAM core's
// precharge/activate/beat/recovery command sequence with registered core outputs
module sdram_cmd_sequencer
  import sdram_pkg::*;
#(
  parameter int TPRE       = 3,
  parameter int TCAS       = 3,
  parameter int TLAT       = 3,
  parameter int TWAIT      = 4,
  parameter int RD_LAT     = 1,
  parameter int WBUF_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_len,
  input  logic [7:0]  req_row,
  input  logic [7:0]  req_col,
  output logic        req_err,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        Precharge,
  output logic        Activate,
  output logic        RE,
  output logic        WE,
  output logic        BS,
  output logic [1:0]  Size,
  output logic [7:0]  RowAddr,
  output logic [7:0]  ColAddr,
  output logic [31:0] DataIn,
  input  logic [31:0] DataOut
);

  state_e      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [3:0]  beats_left;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [7:0]  row_q;
  logic [7:0]  col_q;
  logic        accept, err_d, issue;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_avail;
  logic [31:0] fifo_head;
  logic [RD_LAT-1:0] rd_pipe;

  sdram_wr_fifo #(.DEPTH(WBUF_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wdata_ready = !fifo_full;
  assign fifo_push   = wdata_valid && !fifo_full;
  assign fifo_avail  = !fifo_empty || fifo_push;
  assign req_ready   = (state == ST_IDLE);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    err_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_size == SZ_BAD) err_d = 1'b1;
          else begin
            accept  = 1'b1;
            state_d = ST_PRE;
          end
        end
      end
      ST_PRE: begin
        state_d = ST_PRE_WAIT;
        cnt_d   = 4'(TPRE - 2);
      end
      ST_PRE_WAIT: begin
        if (cnt == 4'd0) state_d = ST_ACT;
        else cnt_d = cnt - 4'd1;
      end
      ST_ACT: begin
        state_d = ST_ACT_WAIT;
        cnt_d   = 4'(TCAS - 2);
      end
      ST_ACT_WAIT: begin
        if (cnt == 4'd0) begin
          if (wr_q) state_d = ST_XFER;
          else begin
            state_d = ST_LAT_WAIT;
            cnt_d   = 4'(TLAT - 1);
          end
        end else cnt_d = cnt - 4'd1;
      end
      ST_LAT_WAIT: begin
        if (cnt == 4'd0) state_d = ST_XFER;
        else cnt_d = cnt - 4'd1;
      end
      ST_XFER: begin
        // beats_left hits zero once the final beat is already on the bus.
        if (beats_left == 4'd0) begin
          state_d = ST_RECOVER;
          cnt_d   = 4'(TWAIT - 1);
        end
      end
      ST_RECOVER: begin
        if (cnt == 4'd0) state_d = ST_IDLE;
        else cnt_d = cnt - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decided one cycle ahead so the beat strobes can be registered.
  assign issue    = (state_d == ST_XFER) && (beats_left != 4'd0) && (!wr_q || fifo_avail);
  assign fifo_pop = issue && wr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      beats_left <= '0;
      wr_q       <= 1'b0;
      size_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        wr_q       <= req_write;
        size_q     <= req_size;
        row_q      <= req_row;
        col_q      <= req_col;
        beats_left <= len_beats(req_len);
      end else if (issue) begin
        beats_left <= beats_left - 4'd1;
        col_q      <= col_q + col_inc(size_q);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Precharge <= 1'b0;
      Activate  <= 1'b0;
      RE        <= 1'b0;
      WE        <= 1'b0;
      BS        <= 1'b1;
      Size      <= '0;
      RowAddr   <= '0;
      ColAddr   <= '0;
      DataIn    <= '0;
      req_err   <= 1'b0;
    end else begin
      Precharge <= (state_d == ST_PRE);
      Activate  <= (state_d == ST_ACT);
      RE        <= issue && !wr_q;
      WE        <= issue && wr_q;
      BS        <= !((state_d == ST_PRE) || (state_d == ST_ACT) || issue);
      req_err   <= err_d;
      if (state_d == ST_ACT) RowAddr <= row_q;
      if (issue) begin
        Size    <= size_q;
        ColAddr <= col_q;
      end
      if (fifo_pop) DataIn <= fifo_head;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pipe     <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      rd_pipe[0] <= RE;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      rdata_valid <= rd_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) rdata <= DataOut;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// tb/tb_sdram_cmd_sequencer.sv - directed and randomized bench with a schedule-level reference model
module tb_sdram_cmd_sequencer;

  localparam int TPRE   = 3;
  localparam int TCAS   = 3;
  localparam int TLAT   = 3;
  localparam int TWAIT  = 4;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_err;
  logic [1:0]  req_size, req_len;
  logic [7:0]  req_row, req_col;
  logic [31:0] wdata, rdata, DataIn, DataOut;
  logic        wdata_valid, wdata_ready, rdata_valid;
  logic        Precharge, Activate, RE, WE, BS;
  logic [1:0]  Size;
  logic [7:0]  RowAddr, ColAddr;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] mq[$];
  int          sched[$];
  logic [31:0] sdat[$];
  logic [31:0] dout[128];

  sdram_cmd_sequencer #(
    .TPRE(TPRE), .TCAS(TCAS), .TLAT(TLAT), .TWAIT(TWAIT), .RD_LAT(RD_LAT), .WBUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_len(req_len), .req_row(req_row), .req_col(req_col),
    .req_err(req_err),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid),
    .Precharge(Precharge), .Activate(Activate), .RE(RE), .WE(WE), .BS(BS),
    .Size(Size), .RowAddr(RowAddr), .ColAddr(ColAddr),
    .DataIn(DataIn), .DataOut(DataOut)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes_obs();
    return {24'd0, Precharge, Activate, RE, WE, BS, rdata_valid, req_ready, req_err};
  endfunction

  function automatic logic [31:0] strobes_exp(input bit pre, input bit act, input bit re, input bit we,
                                               input bit bs, input bit rv, input bit rdy, input bit err);
    return {24'd0, pre, act, re, we, bs, rv, rdy, err};
  endfunction

  task automatic chk_reset_vals(input string tag);
    check({tag, " strobes"}, strobes_obs(), strobes_exp(0, 0, 0, 0, 1, 0, 1, 0));
    check({tag, " size"}, 32'(Size), 32'd0);
    check({tag, " row"}, 32'(RowAddr), 32'd0);
    check({tag, " col"}, 32'(ColAddr), 32'd0);
    check({tag, " datain"}, DataIn, 32'd0);
    check({tag, " rdata"}, rdata, 32'd0);
    check({tag, " wready"}, 32'(wdata_ready), 32'd1);
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      tick();
      check($sformatf("%s idle%0d", tag, i), strobes_obs(), strobes_exp(0, 0, 0, 0, 1, 0, 1, 0));
    end
  endtask

  task automatic push_idle(input logic [31:0] d);
    bit room;
    tick();
    room = (mq.size() < DEPTH);
    check($sformatf("wready n%0d", mq.size()), 32'(wdata_ready), 32'(room));
    wdata_valid = 1'b1;
    wdata = d;
    if (room) mq.push_back(d);
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic do_err();
    tick();
    req_valid = 1'b1;
    req_write = 1'($urandom_range(0, 1));
    req_size  = 2'b11;
    req_len   = 2'($urandom_range(0, 3));
    tick();
    req_valid = 1'b0;
    check("err c1", strobes_obs(), strobes_exp(0, 0, 0, 0, 1, 0, 1, 1));
    tick();
    check("err c2", strobes_obs(), strobes_exp(0, 0, 0, 0, 1, 0, 1, 0));
    tick();
    check("err c3", strobes_obs(), strobes_exp(0, 0, 0, 0, 1, 0, 1, 0));
  endtask

  // Expected schedule: fixed Precharge/Activate slots, beats no earlier than
  // their data is available, recovery then ready.
  task automatic do_req(input bit wr, input logic [1:0] sz, input logic [1:0] ln,
                        input logic [7:0] row, input logic [7:0] col, input int abort_at);
    int n, inc, first, ready, bi, t, pcyc;
    int beat[8];
    int avail[$];
    bit isb, isrv, pre, act;
    n   = 1 << ln;
    inc = 1 << sz;
    foreach (mq[i]) avail.push_back(0);
    foreach (sched[i]) begin
      mq.push_back(sdat[i]);
      avail.push_back(sched[i] + 1);
    end
    first = 1 + TPRE + TCAS + (wr ? 0 : TLAT);
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? first : beat[i-1] + 1;
      if (wr && avail[i] > t) t = avail[i];
      beat[i] = t;
    end
    ready = beat[n-1] + TWAIT + 1;

    tick();
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_len   = ln;
    req_row   = row;
    req_col   = col;
    for (int c = 1; c <= ready; c++) begin
      tick();
      isb = 0;
      isrv = 0;
      bi = 0;
      for (int i = 0; i < n; i++) begin
        if (beat[i] == c) begin isb = 1; bi = i; end
        if (!wr && beat[i] + RD_LAT + 1 == c) isrv = 1;
      end
      pre = (c == 1);
      act = (c == 1 + TPRE);
      check($sformatf("strobes c%0d", c), strobes_obs(),
            strobes_exp(pre, act, !wr && isb, wr && isb, !(pre || act || isb), isrv, c == ready, 0));
      if (act) check($sformatf("row c%0d", c), 32'(RowAddr), 32'(row));
      if (isb) begin
        check($sformatf("col c%0d", c), 32'(ColAddr), 32'(8'(col + bi * inc)));
        check($sformatf("size c%0d", c), 32'(Size), 32'(sz));
        if (wr) check($sformatf("datain c%0d", c), DataIn, mq[bi]);
      end
      if (isrv) check($sformatf("rdata c%0d", c), rdata, dout[c-1]);
      if (c == abort_at) begin
        reset = 1'b0;
        #1;
        chk_reset_vals("abort");
        req_valid = 1'b0;
        wdata_valid = 1'b0;
        mq.delete();
        sched.delete();
        sdat.delete();
        return;
      end
      req_valid = 1'b0;
      wdata_valid = 1'b0;
      foreach (sched[j]) begin
        pcyc = sched[j];
        if (pcyc == c) begin
          wdata_valid = 1'b1;
          wdata = sdat[j];
        end
      end
      DataOut = $urandom;
      dout[c] = DataOut;
    end
    if (wr) repeat (n) void'(mq.pop_front());
    sched.delete();
    sdat.delete();
  endtask

  initial begin
    bit         rwr;
    logic [1:0] rsz, rln;
    int         need, kpre, rest, p;

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_len = 2'b00;
    req_row = 8'h00; req_col = 8'h00;
    wdata = 32'h0; wdata_valid = 1'b0; DataOut = 32'h0;
    #1 reset = 1'b0;
    tick();
    tick();
    chk_reset_vals("por");
    reset = 1'b1;
    idle_check("post_por", 2);

    // Two-beat byte write from preloaded data.
    push_idle(32'h11223344);
    push_idle(32'hABABABAB);
    do_req(1, 2'b00, 2'd1, 8'h00, 8'h00, 0);

    // Four-beat halfword read.
    do_req(0, 2'b01, 2'd2, 8'($urandom), 8'h00, 0);

    // Word write with empty FIFO; data trickles in and stalls the second beat.
    sched.push_back(9);  sdat.push_back(32'hEEFFEEFF);
    sched.push_back(11); sdat.push_back(32'hAABBAABB);
    do_req(1, 2'b10, 2'd1, 8'h5A, 8'h08, 0);

    // Eight-beat word read wrapping the column.
    do_req(0, 2'b10, 2'd3, 8'h33, 8'hFC, 0);

    do_err();

    // Fill past capacity; the ninth push is refused, then drain with eight beats.
    for (int i = 0; i < DEPTH + 1; i++) push_idle($urandom);
    do_req(1, 2'b00, 2'd3, 8'($urandom), 8'($urandom), 0);

    // Reset during the third beat of an eight-beat read.
    do_req(0, 2'b10, 2'd3, 8'($urandom), 8'($urandom), 1 + TPRE + TCAS + TLAT + 2);
    tick();
    tick();
    chk_reset_vals("rst_hold");
    reset = 1'b1;
    idle_check("post_abort", 4);
    push_idle($urandom);
    push_idle($urandom);
    do_req(1, 2'b00, 2'd1, 8'($urandom), 8'h00, 0);

    for (int k = 0; k < 12; k++) begin
      rwr = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 2));
      rln = 2'($urandom_range(0, 3));
      if (rwr) begin
        need = (1 << rln) - mq.size();
        if (need < 0) need = 0;
        kpre = int'($urandom_range(0, need));
        rest = need - kpre;
        for (int i = 0; i < kpre; i++) push_idle($urandom);
        if ($urandom_range(0, 1) == 1 && mq.size() + rest < DEPTH) push_idle($urandom);
        p = int'($urandom_range(1, 8));
        for (int i = 0; i < rest; i++) begin
          sched.push_back(p);
          sdat.push_back($urandom);
          p += int'($urandom_range(1, 3));
        end
      end
      do_req(rwr, rsz, rln, 8'($urandom), 8'($urandom), 0);
    end

    idle_check("final", 3);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_sequencer.md
Name: sdram_cmd_sequencer

Overview:
- Directly upstream of SDRAMMemoryCore: turns one bus-side burst request into the core's command sequence (Precharge, TPRE, Activate, TCAS, optional TLAT, data beats, TWAIT).
- Buffers write data in a small FIFO and returns read data with a valid strobe.
- All core-facing outputs are registered.

Parameters:
TPRE, 3, cycles from Precharge to Activate (Precharge cycle included)
TCAS, 3, cycles from Activate to first write beat (Activate cycle included)
TLAT, 3, extra idle cycles inserted before the first read beat
TWAIT, 4, recovery cycles after the last beat; must be >= RD_LAT+1
RD_LAT, 1, core DataOut valid RD_LAT cycles after its RE cycle
WBUF_DEPTH, 8, write FIFO entries (power of 2, >= 8)

Ports:
clk  in  1  clock; everything on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; accept on valid&ready
req_write  in  1  1=write, 0=read
req_size  in  2  00=B, 01=HW, 10=W, 11 illegal
req_len  in  2  burst beats: 0->1, 1->2, 2->4, 3->8
req_row  in  8  row address
req_col  in  8  start column (byte address)
req_err  out  1  one-cycle pulse: request rejected
wdata  in  32  write beat data
wdata_valid  in  1  push strobe
wdata_ready  out  1  FIFO not full
rdata  out  32  registered read beat
rdata_valid  out  1  one cycle per read beat
Precharge, Activate, RE, WE  out  1 each  core commands
BS  out  1  core chip select, active-low
Size  out  2  beat size to core
RowAddr, ColAddr  out  8 each  core addresses
DataIn  out  32  core write data
DataOut  in  32  core read data

Behaviour:
- Reset (async, reset=0):
  - Precharge, Activate, RE, WE, rdata_valid, req_err are 0. BS is 1. Size, RowAddr, ColAddr, DataIn, rdata are 0.
  - FSM goes to IDLE. FIFO is emptied. Read-latency pipe is cleared.
  - Reset mid-burst aborts the burst; no beat is issued after reset deasserts until a new request.
- States:
  - IDLE: accept request. req_size==11 -> req_err pulse next cycle, stay IDLE.
  - PRE: 1 cycle; Precharge=1, BS=0.
  - PRE_WAIT: TPRE-1 cycles; BS=1.
  - ACT: 1 cycle; Activate=1, BS=0, RowAddr=row.
  - ACT_WAIT: TCAS-1 cycles.
  - LAT_WAIT: reads only, TLAT cycles.
  - XFER: burst beats.
  - RECOVER: TWAIT cycles, then IDLE.
- Cycle count: request accepted at edge 0; PRE occupies cycle 1.
- Beats:
  - Each beat is one cycle with BS=0, Size=latched size, ColAddr=current column.
  - WE=1 with DataIn=FIFO head for writes; RE=1 for reads.
  - After each beat the column advances by 1, 2 or 4 (B, HW, W) and wraps mod 256.
- Write stall: if the FIFO is empty when a write beat is due, the beat is not issued (WE=0, BS=1, column held) until data arrives. One FIFO pop per issued beat.
- Write data ahead of request: data may be pushed before or during the request. Excess FIFO entries carry over to the next write.
- Read return: RE in cycle k -> DataOut sampled at the end of cycle k+RD_LAT -> rdata_valid=1 in cycle k+RD_LAT+1.
- Non-command cycles: all command strobes 0 and BS=1.
- Simultaneous push and pop: both happen and the count is unchanged. A push while full is ignored (wdata_ready=0).
- DataIn holds its last value when WE=0.

Decomposition:
- sdram_pkg: size codes B/HW/W, state enum, len-to-beats decode, size-to-column-increment function.
- One sub-module: sdram_wr_fifo (synchronous FIFO, count/full/empty, same clk/reset).

Test Plan:
1. Write B, len=1 (2 beats), row 00, col 00, data 11223344 and ABABABAB preloaded:
   - Precharge cycle 1, Activate cycle 4.
   - WE cycles 7 and 8 with ColAddr 00 then 01, DataIn 11223344 then ABABABAB.
   - BS=0 only in cycles 1, 4, 7, 8. req_ready returns in cycle 13.
2. Read HW, len=2 (4 beats), col 00:
   - RE cycles 10–13 with ColAddr 00, 02, 04, 06.
   - rdata_valid cycles 12–15 carrying the DataOut values returned.
   - req_ready returns in cycle 18.
3. Write W, len=1, col 08, with the FIFO empty at acceptance; EEFFEEFF pushed in cycle 9 and AABBAABB in cycle 11:
   - Beats in cycles 10 (ColAddr 08) and 12 (ColAddr 0C). Cycle 11 has WE=0, BS=1.
4. Read W, len=3, col FC:
   - ColAddr sequence FC, 00, 04, 08, 0C, 10, 14, 18 (wrap).
   - Exactly 8 rdata_valid pulses.
5. req_size=11 -> req_err pulses once; no Precharge; req_ready stays high.
6. reset=0 asynchronously during the third beat of an 8-beat read:
   - Outputs go to reset values immediately; no further rdata_valid.
   - A following write with col 00 runs normally from cycle 1.
